// File: rtl/data_bus_pkg.sv
// Shared constants and types for the data-side memory system:
// MMIO register offsets, STATUS bit positions and reset constants.
package data_bus_pkg;

  localparam logic [3:0] TXDATA_OFF   = 4'h0;
  localparam logic [3:0] STATUS_OFF   = 4'h4;
  localparam logic [3:0] MTIME_OFF    = 4'h8;
  localparam logic [3:0] MTIMECMP_OFF = 4'hC;

  localparam logic [1:0] STAT_EMPTY = 2'd0;
  localparam logic [1:0] STAT_FULL  = 2'd1;
  localparam logic [1:0] STAT_OVF   = 2'd2;
  localparam logic [1:0] STAT_PEND  = 2'd3;

  localparam logic [31:0] MTIMECMP_RST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    SEL_NONE     = 3'd0,
    SEL_RAM      = 3'd1,
    SEL_TXDATA   = 3'd2,
    SEL_STATUS   = 3'd3,
    SEL_MTIME    = 3'd4,
    SEL_MTIMECMP = 3'd5
  } sel_e;

endpackage

// File: rtl/data_bus_sync_fifo.sv
// Synchronous FIFO without bypass; a full FIFO still accepts a push when
// the head is popped in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == (PW+1)'(0));
  assign full      = (count_r == (PW+1)'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  // Head is forced to zero while empty so the output is defined after reset.
  assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage array; contents are meaningless until a push, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s && !reset) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/data_bus.sv
// Data-side memory system: word RAM plus MMIO block (console TX FIFO,
// STATUS, free-running timer with compare interrupt). Reads are same-cycle.
module data_bus
  import data_bus_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   ram_r [RAM_WORDS];
  logic [AW-1:0] ram_idx_s;
  sel_e          sel_s;
  logic [31:0]   mtime_r;
  logic [31:0]   mtimecmp_r;
  logic          pending_r;
  logic          overflow_r;
  logic          push_s;
  logic          pop_s;
  logic          empty_s;
  logic          full_s;
  logic          wr_status_s;
  logic          unused_addr_s;

  assign ram_idx_s     = addr[AW+1:2];
  assign unused_addr_s = ^addr[1:0];

  // Address decode into a single target select.
  always_comb begin
    sel_s = SEL_NONE;
    if (addr[31:AW+2] == {(30-AW){1'b0}}) begin
      sel_s = SEL_RAM;
    end else if (addr[31:4] == MMIO_BASE[31:4]) begin
      case ({addr[3:2], 2'b00})
        TXDATA_OFF:   sel_s = SEL_TXDATA;
        STATUS_OFF:   sel_s = SEL_STATUS;
        MTIME_OFF:    sel_s = SEL_MTIME;
        MTIMECMP_OFF: sel_s = SEL_MTIMECMP;
        default:      sel_s = SEL_NONE;
      endcase
    end else begin
      sel_s = SEL_NONE;
    end
  end

  assign push_s      = mem_write && (sel_s == SEL_TXDATA);
  assign pop_s       = tx_valid && tx_ready;
  assign wr_status_s = mem_write && (sel_s == SEL_STATUS);
  assign tx_valid    = !empty_s;
  assign timer_irq   = pending_r;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (wdata[7:0]),
    .dout  (tx_data),
    .empty (empty_s),
    .full  (full_s)
  );

  // Data RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_write && (sel_s == SEL_RAM)) begin
      ram_r[ram_idx_s] <= wdata;
    end
  end

  // Timer, compare flag and sticky overflow; set beats a same-cycle W1C clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_r    <= 32'd0;
      mtimecmp_r <= MTIMECMP_RST;
      pending_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (mem_write && (sel_s == SEL_MTIME)) begin
        mtime_r <= wdata;
      end else begin
        mtime_r <= mtime_r + 32'd1;
      end
      if (mem_write && (sel_s == SEL_MTIMECMP)) begin
        mtimecmp_r <= wdata;
      end
      if (mtime_r == mtimecmp_r) begin
        pending_r <= 1'b1;
      end else if (wr_status_s && wdata[STAT_PEND]) begin
        pending_r <= 1'b0;
      end
      if (push_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end else if (wr_status_s && wdata[STAT_OVF]) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Combinational read mux for the single-cycle core.
  always_comb begin
    rdata = 32'd0;
    case (sel_s)
      SEL_RAM:      rdata = ram_r[ram_idx_s];
      SEL_STATUS:   rdata = {28'd0, pending_r, overflow_r, full_s, empty_s};
      SEL_MTIME:    rdata = mtime_r;
      SEL_MTIMECMP: rdata = mtimecmp_r;
      default:      rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_data_bus.sv
// Directed self-checking bench for data_bus: RAM, TX FIFO, STATUS, timer
// and reset behaviour with hand-computed expectations.
module tb_data_bus;

  localparam logic [31:0] BASE     = 32'h1000_0000;
  localparam logic [31:0] A_TXDATA = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_MTIME  = BASE + 32'h8;
  localparam logic [31:0] A_MTCMP  = BASE + 32'hC;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  data_bus #(
    .RAM_WORDS  (1024),
    .FIFO_DEPTH (8),
    .MMIO_BASE  (32'h1000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1;
    addr      = a;
    wdata     = d;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic test_reset;
    bus_read(A_MTIME, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_mtime got %h want %h", rd, 32'd0); end
    bus_read(A_MTCMP, rd);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_mtimecmp got %h want %h", rd, 32'hFFFF_FFFF); end
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL reset_status got %h want %h", rd, 32'h1); end
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx got v=%b d=%h want v=0 d=00", tx_valid, tx_data); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", timer_irq); end
  endtask

  task automatic test_ram;
    bus_write(32'h10, 32'h1234_5678);
    mem_write = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL ram_same_cycle got %h want %h", rdata, 32'h1234_5678); end
    @(posedge clk); #1;
    mem_write = 1'b0;
    bus_read(32'h10, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_next_cycle got %h want %h", rd, 32'hDEAD_BEEF); end
    bus_read(32'h13, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_byte_offset got %h want %h", rd, 32'hDEAD_BEEF); end
    bus_write(32'hFFC, 32'hCAFE_F00D);
    bus_read(32'hFFC, rd);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_top_word got %h want %h", rd, 32'hCAFE_F00D); end
    bus_read(32'h10, rd);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_no_alias got %h want %h", rd, 32'hDEAD_BEEF); end
  endtask

  task automatic test_overflow;
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) bus_write(A_TXDATA, 32'h41 + 32'(i));
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h6) begin errors++; $display("FAIL ovf_status got %h want %h", rd, 32'h6); end
    #10;
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL ovf_hold got v=%b d=%h want v=1 d=41", tx_valid, tx_data); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        errors++; $display("FAIL ovf_drain[%0d] got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", tx_valid); end
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h5) begin errors++; $display("FAIL ovf_status_drained got %h want %h", rd, 32'h5); end
    bus_write(A_STATUS, 32'h4);
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ovf_w1c got %h want %h", rd, 32'h1); end
  endtask

  task automatic test_full_boundary;
    logic [7:0] exp_b;
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(A_TXDATA, 32'h50 + 32'(i));
    tx_ready = 1'b1;
    bus_write(A_TXDATA, 32'h5A);
    tx_ready = 1'b0;
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL full_push_pop_status got %h want %h", rd, 32'h2); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_b = (i == 7) ? 8'h5A : 8'(8'h51 + i);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b) begin
        errors++; $display("FAIL full_drain[%0d] got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp_b);
      end
      @(posedge clk); #1;
    end
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %b want 0", tx_valid); end
  endtask

  task automatic test_timer;
    bus_write(A_MTCMP, 32'd20);
    bus_write(A_MTIME, 32'd10);
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      checks++;
      if (timer_irq !== ((k == 11) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL timer_irq_edge%0d got %b want %b", k, timer_irq, (k == 11));
      end
    end
    bus_write(A_STATUS, 32'h8);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL timer_w1c got %b want 0", timer_irq); end
    bus_write(A_MTIME, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_read(A_MTIME, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL timer_wrap got %h want %h", rd, 32'd0); end
  endtask

  task automatic test_set_clear;
    bus_write(A_MTCMP, 32'd100);
    bus_write(A_MTIME, 32'd50);
    repeat (50) @(posedge clk);
    #1;
    bus_read(A_MTIME, rd);
    checks++; if (rd !== 32'd100) begin errors++; $display("FAIL setclr_mtime got %h want %h", rd, 32'd100); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL setclr_before got %b want 0", timer_irq); end
    bus_write(A_STATUS, 32'h8);
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL setclr_priority got %b want 1", timer_irq); end
    bus_write(A_STATUS, 32'h8);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL setclr_later_clear got %b want 0", timer_irq); end
  endtask

  task automatic test_reset_mid;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus_write(A_TXDATA, 32'h61 + 32'(i));
    tx_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (tx_data !== 8'h62) begin errors++; $display("FAIL rstmid_head got %h want %h", tx_data, 8'h62); end
    reset = 1'b1; mem_write = 1'b1; addr = A_TXDATA; wdata = 32'h70;
    @(posedge clk); #1;
    reset = 1'b0; mem_write = 1'b0; tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx got v=%b d=%h want v=0 d=00", tx_valid, tx_data); end
    bus_read(A_MTIME, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rstmid_mtime got %h want %h", rd, 32'd0); end
    bus_read(A_MTCMP, rd);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rstmid_mtimecmp got %h want %h", rd, 32'hFFFF_FFFF); end
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rstmid_status got %h want %h", rd, 32'h1); end
  endtask

  task automatic test_unmapped;
    bus_write(32'h0, 32'hA5A5_A5A5);
    bus_write(32'h1000, 32'h5A5A_5A5A);
    bus_write(BASE + 32'h10, 32'hF);
    bus_read(32'h0, rd);
    checks++; if (rd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL unmap_no_alias got %h want %h", rd, 32'hA5A5_A5A5); end
    bus_read(32'h1000, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL unmap_ram_end got %h want 0", rd); end
    bus_read(32'h2000_0000, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL unmap_far got %h want 0", rd); end
    bus_read(BASE + 32'h10, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL unmap_mmio got %h want 0", rd); end
    bus_read(A_TXDATA, rd);
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL txdata_read got %h want 0", rd); end
    bus_read(A_STATUS, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL unmap_side_effect got %h want %h", rd, 32'h1); end
  endtask

  initial begin
    reset = 1'b1; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset;
    test_ram;
    test_overflow;
    test_full_boundary;
    test_timer;
    test_set_clear;
    test_reset_mid;
    test_unmapped;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
